led_mode_sequencer: RTL and testbench

Pattern controller for the iCEBreaker LED bank: owns the five user LEDs and the green/red active-low LEDs and sequences them through selectable display modes. A free-running prescaler paces pattern steps; a single-cycle NEXT pulse from the upstream button debouncer advances the mode. It replaces bare counter-driven LED wiring at the board top level.

---
 rtl/led_seq_pkg.sv | 49 ++++
 rtl/led_mode_sequencer_prescaler.sv | 34 +++
 rtl/led_mode_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_led_mode_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_pkg
// Purpose  : Shared types and constants for the LED mode sequencer:
//            display-mode enum, per-mode entry patterns, LED bank width.
// Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

  localparam int LED_W = 5;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  localparam logic [LED_W-1:0] PAT_OFF   = 5'b00000;
  localparam logic [LED_W-1:0] PAT_BLINK = 5'b11111;
  localparam logic [LED_W-1:0] PAT_CHASE = 5'b00001;
  localparam logic [LED_W-1:0] PAT_COUNT = 5'b00000;

  // Mode order is OFF -> BLINK -> CHASE -> COUNT -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:   n = MODE_BLINK;
      MODE_BLINK: n = MODE_CHASE;
      MODE_CHASE: n = MODE_COUNT;
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

  // Pattern loaded whenever a mode is entered.
  function automatic logic [LED_W-1:0] entry_pat(input mode_t m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_OFF:   p = PAT_OFF;
      MODE_BLINK: p = PAT_BLINK;
      MODE_CHASE: p = PAT_CHASE;
      default:    p = PAT_COUNT;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_sequencer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : led_prescaler
// Purpose  : Free-running WIDTH-bit step prescaler with synchronous clear.
//            tick is high while the counter is all-ones, i.e. on the cycle
//            whose closing edge wraps the counter back to zero.
// Revision : 1.0 - initial release
// ============================================================================
module led_prescaler #(
  parameter int WIDTH = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [WIDTH-1:0] cnt;

  // Count up, wrapping naturally; clr restarts the step period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = &cnt;

endmodule
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sequencer
// Purpose  : LED bank pattern controller. A NEXT pulse cycles the display
//            mode (OFF/BLINK/CHASE/COUNT); a prescaler tick steps the pattern
//            unless HOLD is high. All LED outputs are registered.
//            Optional macro LED_SEQ_PWM_EN adds a BRIGHT input that gates
//            every LED with a free-running PWM counter.
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int PRESCALE_W = 22
`ifdef LED_SEQ_PWM_EN
  , parameter int PWM_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next,
  input  logic             hold,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_W-1:0] bright,
`endif
  output logic [1:0]       mode,
  output logic             led1,
  output logic             led2,
  output logic             led3,
  output logic             led4,
  output logic             led5,
  output logic             ledg_n,
  output logic             ledr_n
);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [LED_W-1:0] PAT_LEFT_END  = 5'b10000;
  localparam logic [LED_W-1:0] PAT_RIGHT_END = 5'b00001;

  mode_t            cur_mode;
  mode_t            new_mode;
  logic [LED_W-1:0] pat;
  logic             dir;
  logic             tick;

  logic [LED_W-1:0] step_pat;
  logic             step_dir;

  logic [LED_W-1:0] led_d;
  logic             ledg_d;
  logic             ledr_d;

  logic [LED_W-1:0] led_reg;
  logic             ledg_reg;
  logic             ledr_reg;

  // A mode change restarts the step period so the entry pattern shows for a
  // full period.
  led_prescaler #(
    .WIDTH (PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (next),
    .tick (tick)
  );

  assign new_mode = next_mode(cur_mode);

  // Next pattern/direction for a step in the current mode.
  always_comb begin
    step_pat = pat;
    step_dir = dir;
    case (cur_mode)
      MODE_BLINK: step_pat = ~pat;
      MODE_CHASE: begin
        if (dir == DIR_LEFT) begin
          if (pat == PAT_LEFT_END) begin
            step_dir = DIR_RIGHT;
            step_pat = pat >> 1;
          end else begin
            step_pat = pat << 1;
          end
        end else begin
          if (pat == PAT_RIGHT_END) begin
            step_dir = DIR_LEFT;
            step_pat = pat << 1;
          end else begin
            step_pat = pat >> 1;
          end
        end
      end
      MODE_COUNT: step_pat = pat + 1'b1;
      default: ;
    endcase
  end

  // Mode FSM and pattern state; NEXT takes priority over a coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode <= MODE_OFF;
      pat      <= PAT_OFF;
      dir      <= DIR_LEFT;
    end else if (next) begin
      cur_mode <= new_mode;
      pat      <= entry_pat(new_mode);
      dir      <= DIR_LEFT;
    end else if (tick && !hold) begin
      pat <= step_pat;
      dir <= step_dir;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             lit;

  // Free-running brightness counter; never cleared by mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign lit = (pwm_cnt < bright);
`endif

  // Raw LED drive derived from mode, pattern and direction, then gated.
  always_comb begin
    led_d  = pat;
    ledg_d = 1'b1;
    ledr_d = 1'b1;
    case (cur_mode)
      MODE_BLINK: begin
        ledg_d = ~pat[0];
        ledr_d = pat[0];
      end
      MODE_CHASE: begin
        ledg_d = (dir != DIR_LEFT);
        ledr_d = (dir != DIR_RIGHT);
      end
      MODE_COUNT: begin
        ledg_d = ~pat[0];
        ledr_d = (pat != '0);
      end
      default: ;
    endcase
`ifdef LED_SEQ_PWM_EN
    // Outside the duty window every LED is forced dark.
    led_d  = led_d & {LED_W{lit}};
    ledg_d = ledg_d | ~lit;
    ledr_d = ledr_d | ~lit;
`endif
  end

  // Output registers: no combinational path from inputs to pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg  <= '0;
      ledg_reg <= 1'b1;
      ledr_reg <= 1'b1;
    end else begin
      led_reg  <= led_d;
      ledg_reg <= ledg_d;
      ledr_reg <= ledr_d;
    end
  end

  assign mode   = cur_mode;
  assign led1   = led_reg[0];
  assign led2   = led_reg[1];
  assign led3   = led_reg[2];
  assign led4   = led_reg[3];
  assign led5   = led_reg[4];
  assign ledg_n = ledg_reg;
  assign ledr_n = ledr_reg;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sequencer
// Purpose  : Directed self-checking bench for led_mode_sequencer with a
//            3-bit prescaler (one step every 8 cycles). With LED_SEQ_PWM_EN
//            defined it exercises the brightness gate (PWM_W=2) instead.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       next = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] mode;
  logic       led1, led2, led3, led4, led5;
  logic       ledg_n, ledr_n;
`ifdef LED_SEQ_PWM_EN
  logic [1:0] bright = 2'd0;
`endif

  logic [8:0] obs;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .PRESCALE_W (3)
`ifdef LED_SEQ_PWM_EN
    , .PWM_W    (2)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .next   (next),
    .hold   (hold),
`ifdef LED_SEQ_PWM_EN
    .bright (bright),
`endif
    .mode   (mode),
    .led1   (led1),
    .led2   (led2),
    .led3   (led3),
    .led4   (led4),
    .led5   (led5),
    .ledg_n (ledg_n),
    .ledr_n (ledr_n)
  );

  assign obs = {mode, led5, led4, led3, led2, led1, ledg_n, ledr_n};

  function automatic logic [8:0] pk(input logic [1:0] m, input logic [4:0] l,
                                    input logic g, input logic r);
    return {m, l, g, r};
  endfunction

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed mode/leds/g/r=%b expected %b", tag, o, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_next();
    next = 1'b1;
    cyc(1);
    next = 1'b0;
  endtask

  logic [4:0] chase_seq [10];
  logic       chase_right [10];
  logic [4:0] v;
  logic       on;
  int         c_l1, c_g, c_r;

  initial begin
    chase_seq   = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h02};
    chase_right = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    cyc(2);
    check("reset", obs, pk(2'd0, 5'h00, 1'b1, 1'b1));
    rst = 1'b0;

`ifndef LED_SEQ_PWM_EN
    // Idle in OFF.
    for (int j = 1; j <= 40; j++) begin
      cyc(1);
      check("idle_off", obs, pk(2'd0, 5'h00, 1'b1, 1'b1));
    end

    // BLINK: mode changes at the NEXT edge, LEDs one edge later.
    pulse_next();
    check("blink_enter", obs, pk(2'd1, 5'h00, 1'b1, 1'b1));
    for (int j = 1; j <= 32; j++) begin
      cyc(1);
      on = (((j - 1) / 8) % 2) == 0;
      check("blink", obs, pk(2'd1, on ? 5'h1F : 5'h00, ~on, on));
    end

    // Reset, then back-to-back NEXT pulses into CHASE.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    next = 1'b1;
    cyc(1);
    check("b2b_first", obs, pk(2'd1, 5'h00, 1'b1, 1'b1));
    cyc(1);
    next = 1'b0;
    check("b2b_second", obs, pk(2'd2, 5'h1F, 1'b0, 1'b1));
    for (int j = 1; j <= 80; j++) begin
      cyc(1);
      check("chase", obs, pk(2'd2, chase_seq[(j - 1) / 8],
                             chase_right[(j - 1) / 8], ~chase_right[(j - 1) / 8]));
    end

    // COUNT through a full wrap.
    pulse_next();
    check("count_enter", obs, pk(2'd3, 5'h04, 1'b0, 1'b1));
    for (int j = 1; j <= 264; j++) begin
      cyc(1);
      v = 5'(((j - 1) / 8) % 32);
      check("count", obs, pk(2'd3, v, ~v[0], (v != 5'd0)));
    end

    // HOLD for three ticks freezes the value; prescaler keeps its phase.
    hold = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      cyc(1);
      check("hold", obs, pk(2'd3, 5'h01, 1'b0, 1'b1));
    end
    hold = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      cyc(1);
      v = (j <= 8) ? 5'd1 : 5'd2;
      check("after_hold", obs, pk(2'd3, v, ~v[0], 1'b1));
    end

    // NEXT coincident with tick: NEXT wins, no step.
    cyc(7);
    pulse_next();
    check("next_tick_off", obs, pk(2'd0, 5'h03, 1'b0, 1'b1));
    for (int j = 1; j <= 7; j++) begin
      cyc(1);
      check("off_again", obs, pk(2'd0, 5'h00, 1'b1, 1'b1));
    end
    pulse_next();
    check("next_tick_blink", obs, pk(2'd1, 5'h00, 1'b1, 1'b1));
    for (int j = 1; j <= 9; j++) begin
      cyc(1);
      if (j <= 8) check("blink_full_period", obs, pk(2'd1, 5'h1F, 1'b0, 1'b1));
      else        check("blink_full_period", obs, pk(2'd1, 5'h00, 1'b1, 1'b0));
    end

    // Asynchronous reset mid-CHASE.
    pulse_next();
    check("chase_enter2", obs, pk(2'd2, 5'h00, 1'b1, 1'b0));
    cyc(20);
    check("chase_mid", obs, pk(2'd2, 5'h04, 1'b0, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs, pk(2'd0, 5'h00, 1'b1, 1'b1));
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("post_rst_idle", obs, pk(2'd0, 5'h00, 1'b1, 1'b1));
    pulse_next();
    check("post_rst_next", obs, pk(2'd1, 5'h00, 1'b1, 1'b1));
    cyc(1);
    check("post_rst_blink", obs, pk(2'd1, 5'h1F, 1'b0, 1'b1));
`else
    // BRIGHT=0: everything dark in BLINK.
    pulse_next();
    for (int j = 1; j <= 16; j++) begin
      cyc(1);
      check("pwm_dark", obs, pk(2'd1, 5'h00, 1'b1, 1'b1));
    end

    // BRIGHT=2: lit on 2 of every 4 cycles where the pattern lights the LED.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bright = 2'd2;
    pulse_next();
    c_l1 = 0; c_g = 0; c_r = 0;
    for (int j = 1; j <= 4; j++) begin
      cyc(1);
      check("pwm_leds_uniform", {2'd1, {5{led1}}, 2'b00},
            {mode, led5, led4, led3, led2, led1, 2'b00});
      c_l1 += int'(led1);
      c_g  += int'(!ledg_n);
      c_r  += int'(!ledr_n);
    end
    check("pwm_on_led1", 9'(c_l1), 9'd2);
    check("pwm_on_ledg", 9'(c_g), 9'd2);
    check("pwm_on_ledr", 9'(c_r), 9'd0);
    cyc(4);
    c_l1 = 0; c_g = 0; c_r = 0;
    for (int j = 1; j <= 4; j++) begin
      cyc(1);
      c_l1 += int'(led1);
      c_g  += int'(!ledg_n);
      c_r  += int'(!ledr_n);
    end
    check("pwm_off_led1", 9'(c_l1), 9'd0);
    check("pwm_off_ledg", 9'(c_g), 9'd0);
    check("pwm_off_ledr", 9'(c_r), 9'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
